// File: rtl/doorbell_chime_ctrl.sv
// Doorbell chime initiator: debounces the bell push, then plays a "ding" (tone a)
// followed by a "dong" (tone b) while generating both square-wave tones.
module doorbell_chime_ctrl #(
  parameter int DEB_LEN  = 3,
  parameter int DIV_A    = 4,
  parameter int DIV_B    = 6,
  parameter int DING_LEN = 16,
  parameter int DONG_LEN = 24,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic a,
  output logic b,
  output logic sel,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {IDLE, DING, DONG} state_e;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_TOP   = CNT_W'(DEB_LEN);
  localparam logic [CNT_W-1:0] DEB_PRE   = CNT_W'(DEB_LEN - 1);
  localparam logic [CNT_W-1:0] DIV_A_TOP = CNT_W'(DIV_A - 1);
  localparam logic [CNT_W-1:0] DIV_B_TOP = CNT_W'(DIV_B - 1);
  localparam logic [CNT_W-1:0] DING_TOP  = CNT_W'(DING_LEN - 1);
  localparam logic [CNT_W-1:0] DONG_TOP  = CNT_W'(DONG_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0] div_a_cnt_q, div_a_cnt_d;
  logic [CNT_W-1:0] div_b_cnt_q, div_b_cnt_d;
  logic             a_q, a_d, b_q, b_d, sel_q, sel_d, busy_q, busy_d, done_q, done_d;
  logic             press;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    phase_cnt_d = phase_cnt_q;
    div_a_cnt_d = div_a_cnt_q;
    div_b_cnt_d = div_b_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    // The debouncer keeps tracking while busy so a held button cannot retrigger.
    press = button && (deb_cnt_q == DEB_PRE);
    if (!button) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_TOP) begin
      deb_cnt_d = deb_cnt_q + ONE;
    end

    // Tones free-run across both phases; phase is only cleared on chime start/end.
    if (state_q != IDLE) begin
      if (div_a_cnt_q == DIV_A_TOP) begin
        div_a_cnt_d = '0;
        a_d         = ~a_q;
      end else begin
        div_a_cnt_d = div_a_cnt_q + ONE;
      end
      if (div_b_cnt_q == DIV_B_TOP) begin
        div_b_cnt_d = '0;
        b_d         = ~b_q;
      end else begin
        div_b_cnt_d = div_b_cnt_q + ONE;
      end
    end

    case (state_q)
      IDLE: begin
        a_d         = 1'b0;
        b_d         = 1'b0;
        sel_d       = 1'b0;
        busy_d      = 1'b0;
        phase_cnt_d = '0;
        div_a_cnt_d = '0;
        div_b_cnt_d = '0;
        if (press) begin
          state_d = DING;
          busy_d  = 1'b1;
        end
      end
      DING: begin
        if (phase_cnt_q == DING_TOP) begin
          state_d     = DONG;
          phase_cnt_d = '0;
          sel_d       = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + ONE;
        end
      end
      DONG: begin
        if (phase_cnt_q == DONG_TOP) begin
          state_d     = IDLE;
          phase_cnt_d = '0;
          div_a_cnt_d = '0;
          div_b_cnt_d = '0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          sel_d       = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      phase_cnt_q <= '0;
      div_a_cnt_q <= '0;
      div_b_cnt_q <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      div_a_cnt_q <= div_a_cnt_d;
      div_b_cnt_q <= div_b_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_doorbell_chime_ctrl.sv
// Bench for doorbell_chime_ctrl: directed scenarios plus random button/reset traffic,
// compared every cycle against a chime-timeline model.
module tb_doorbell_chime_ctrl;

  localparam int DEB_LEN  = 3;
  localparam int DIV_A    = 4;
  localparam int DIV_B    = 6;
  localparam int DING_LEN = 16;
  localparam int DONG_LEN = 24;
  localparam int CNT_W    = 16;
  localparam int TOTAL    = DING_LEN + DONG_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b0;
  logic a, b, sel, busy, done;

  int checks = 0;
  int failures = 0;

  // Model: debounce count, position inside the chime (-1 = idle), done flag.
  int m_deb = 0;
  int m_k = -1;
  logic m_done = 1'b0;

  int busy_seen = 0;
  int done_seen = 0;

  doorbell_chime_ctrl #(
    .DEB_LEN(DEB_LEN), .DIV_A(DIV_A), .DIV_B(DIV_B),
    .DING_LEN(DING_LEN), .DONG_LEN(DONG_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .a(a), .b(b), .sel(sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic btn);
    bit p;
    if (!r) begin
      m_deb  = 0;
      m_k    = -1;
      m_done = 1'b0;
    end else begin
      p      = btn && (m_deb == DEB_LEN - 1);
      m_deb  = btn ? ((m_deb < DEB_LEN) ? m_deb + 1 : DEB_LEN) : 0;
      m_done = 1'b0;
      if (m_k >= 0) begin
        m_k++;
        if (m_k == TOTAL) begin
          m_k    = -1;
          m_done = 1'b1;
        end
      end else if (p) begin
        m_k = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic btn);
    logic e_busy, e_sel, e_a, e_b;
    rst_n  = r;
    button = btn;
    @(posedge clk);
    model_edge(r, btn);
    #1;
    e_busy = (m_k >= 0);
    e_sel  = (m_k >= DING_LEN);
    e_a    = (m_k >= 0) ? logic'((m_k / DIV_A) % 2) : 1'b0;
    e_b    = (m_k >= 0) ? logic'((m_k / DIV_B) % 2) : 1'b0;
    check("busy", busy, e_busy);
    check("sel", sel, e_sel);
    check("a", a, e_a);
    check("b", b, e_b);
    check("done", done, m_done);
    if (busy === 1'b1) busy_seen++;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic repeat_step(input logic r, input logic btn, input int n);
    for (int i = 0; i < n; i++) step(r, btn);
  endtask

  initial begin
    logic lvl;
    int   run_left;

    // 1: reset with button held, then debounce from scratch after release
    repeat_step(1'b0, 1'b1, 2);
    repeat_step(1'b1, 1'b1, 45);
    repeat_step(1'b1, 1'b0, 10);

    // 2: too-short press
    busy_seen = 0; done_seen = 0;
    repeat_step(1'b1, 1'b1, 2);
    repeat_step(1'b1, 1'b0, 20);
    check_int("t2_busy_cycles", busy_seen, 0);
    check_int("t2_done_pulses", done_seen, 0);

    // 3: single clean chime
    busy_seen = 0; done_seen = 0;
    repeat_step(1'b1, 1'b1, 5);
    repeat_step(1'b1, 1'b0, 50);
    check_int("t3_busy_cycles", busy_seen, TOTAL);
    check_int("t3_done_pulses", done_seen, 1);

    // 4: valid press landing mid-DONG is discarded
    busy_seen = 0; done_seen = 0;
    repeat_step(1'b1, 1'b1, 3);
    for (int i = 0; i < 100 && m_k != 27; i++) step(1'b1, 1'b0);
    repeat_step(1'b1, 1'b1, 3);
    repeat_step(1'b1, 1'b0, 40);
    check_int("t4_busy_cycles", busy_seen, TOTAL);
    check_int("t4_done_pulses", done_seen, 1);

    // 5: long hold gives one chime; a fresh press gives another
    busy_seen = 0; done_seen = 0;
    repeat_step(1'b1, 1'b1, 60);
    check_int("t5_first_done", done_seen, 1);
    repeat_step(1'b1, 1'b0, 1);
    repeat_step(1'b1, 1'b1, 3);
    repeat_step(1'b1, 1'b0, 50);
    check_int("t5_busy_cycles", busy_seen, 2 * TOTAL);
    check_int("t5_done_pulses", done_seen, 2);

    // 6: reset mid-DING, then a full chime
    repeat_step(1'b1, 1'b1, 3);
    for (int i = 0; i < 100 && m_k != 7; i++) step(1'b1, 1'b0);
    busy_seen = 0; done_seen = 0;
    step(1'b0, 1'b0);
    check_int("t6_busy_after_reset", busy_seen, 0);
    repeat_step(1'b1, 1'b0, 2);
    repeat_step(1'b1, 1'b1, 3);
    repeat_step(1'b1, 1'b0, 50);
    check_int("t6_busy_cycles", busy_seen, TOTAL);
    check_int("t6_done_pulses", done_seen, 1);

    // Random button runs with occasional resets
    lvl = 1'b0;
    run_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (run_left == 0) begin
        lvl = ~lvl;
        run_left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 80))
                                               : int'($urandom_range(1, 6));
      end
      run_left--;
      if ($urandom_range(0, 249) == 0) step(1'b0, lvl);
      else step(1'b1, lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/doorbell_chime_ctrl.md
Name: doorbell_chime_ctrl

Overview:
Initiator side of the doorbell chime path. It debounces the bell-push button and generates the two tone waveforms `a` and `b`. It also drives the select line `sel` through a "ding" (tone a) then "dong" (tone b) sequence. Outputs `a`, `b` and `sel` connect directly to the chime multiplexer inputs of the same names. `busy` and `done` are status outputs for higher-level logic.

Parameters:
DEB_LEN, 3, consecutive clocks button must be sampled high to count as a press (>=1)
DIV_A, 4, half-period of tone a in clocks (>=1); tone a period = 2*DIV_A
DIV_B, 6, half-period of tone b in clocks (>=1); tone b period = 2*DIV_B
DING_LEN, 16, clocks spent in DING phase (>=1)
DONG_LEN, 24, clocks spent in DONG phase (>=1)
CNT_W, 16, width of all internal counters; every length/divider parameter must be < 2^CNT_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
button  input  1  bell push, already synchronised to clk, active high
a  output  1  tone a square wave (to mux input a)
b  output  1  tone b square wave (to mux input b)
sel  output  1  tone select (0 = a/ding, 1 = b/dong)
busy  output  1  high while a chime is playing
done  output  1  one-cycle pulse when a chime completes

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, all counters 0.
  - a=b=sel=busy=done=0 after that edge.
  - Reset overrides all other activity, including mid-chime.
- Debounce:
  - deb_cnt increments on each edge with button=1 and saturates at DEB_LEN.
  - deb_cnt clears to 0 on any edge with button=0.
  - A press event occurs on the edge where deb_cnt goes from DEB_LEN-1 to DEB_LEN.
  - Therefore a held button yields exactly one press event; a new press needs button=0 for at least one edge, then DEB_LEN high edges.
- State machine (registered outputs):
  - IDLE: sel=0, busy=0, a=b=0.
    - A press event moves to DING on that same edge.
    - If the button is first sampled high at edge E0, busy=1 is visible after edge E0+DEB_LEN-1.
  - DING: busy=1, sel=0. Lasts exactly DING_LEN cycles, then DONG.
  - DONG: busy=1, sel=1. Lasts exactly DONG_LEN cycles, then IDLE.
  - On the DONG->IDLE edge, done is set to 1 for exactly one cycle, the first IDLE cycle.
  - busy is high for exactly DING_LEN+DONG_LEN cycles.
- Press events while busy=1 are discarded: no queueing, no restart, no extension.
  - The debounce counter keeps tracking during busy, so a button held past the chime end does not retrigger.
- Tone generation:
  - The a and b dividers clear, with a=b=0, on the IDLE->DING edge.
  - Both tones run for the whole busy period, independent of sel.
  - a holds each level for DIV_A cycles; b holds each level for DIV_B cycles. First level is 0 for both.
  - Tone phase is not reset at the DING->DONG transition.
  - a and b are forced to 0 in IDLE.
- Reset mid-chime:
  - Next cycle is IDLE with all outputs 0 and no done pulse.
  - A button held through reset release needs DEB_LEN fresh high samples to produce a press.
- Simultaneous events:
  - A press on the DONG->IDLE edge is discarded, because the FSM is still busy at that edge.
  - done and a new busy can never overlap.

Test Plan:
1. rst_n=0 for 2 edges with button=1 -> a=b=sel=busy=done=0. After release, busy rises only after 3 further high samples.
2. Defaults; button high for 2 cycles, then low -> busy stays 0 and done never pulses.
3. Button high from E0 for 5 cycles -> busy=1 after E2.
   - sel=0 for 16 cycles, then sel=1 for 24 cycles; busy=0 after 40 cycles.
   - done=1 for exactly 1 cycle.
   - a pattern: 4 cycles 0, then 4 cycles 1, repeating (period 8).
   - b pattern: 6 cycles 0, then 6 cycles 1, repeating (period 12).
4. Valid 3-cycle press issued mid-DONG (cycle 30 of busy) -> ignored; busy still falls at cycle 40; no second chime.
5. Button held high for 60 cycles -> exactly one chime. Then low 1 cycle and high 3 cycles -> second chime starts.
6. rst_n=0 at busy cycle 8 (DING) -> next cycle busy=sel=a=b=0, done stays 0. A following press yields a full 40-cycle chime.
